// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- MEM-stage load/store controller.
//
// Takes one load/store request at a time, issues a single one-cycle access on
// the data memory port and returns a registered, size-extracted and
// sign/zero-extended load result (or a zero store completion) over a
// valid/ready response channel.  Misaligned requests never touch memory and
// complete with resp_misalign set.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (ready only when idle)
//   req_addr, req_wen, req_size,    request fields, sampled on the accept edge
//   req_unsigned, req_wdata
//   resp_valid/resp_ready           response handshake
//   resp_rdata, resp_misalign       registered response payload
//   mem_addr, mem_ce, mem_we,       memory port, active only in ACCESS
//   mem_wdata, mem_wmask
//   mem_rdata                       combinational read data from memory
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_misalign,
  output logic [63:0] mem_addr,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;

  logic [63:0] addr_r;
  logic        wen_r;
  logic [1:0]  size_r;
  logic        uns_r;
  logic [63:0] wdata_r;

  logic        resp_valid_r;
  logic [63:0] resp_rdata_r;
  logic        resp_misalign_r;

  logic        accept_s;
  logic        misalign_s;
  logic [7:0]  wmask_s;
  logic [63:0] wdata_sh_s;
  logic [63:0] load_s;

  // A request is misaligned when any offset bit below its natural size is set.
  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = off[0];
      2'd2:    bad = |off[1:0];
      2'd3:    bad = |off[2:0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte enables for an access of 2**size bytes before lane shifting.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      2'd3:    m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  // Select the addressed bytes from a lane and extend them to 64 bits.
  function automatic logic [63:0] extract_load(input logic [63:0] lane, input logic [2:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [63:0] sh;
    logic [63:0] r;
    sh = lane >> {off, 3'b000};
    case (size)
      2'd0:    r = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1:    r = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    r = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      2'd3:    r = sh;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  assign accept_s   = req_valid && (state_r == ST_IDLE);
  assign misalign_s = is_misaligned(req_addr[2:0], req_size);
  assign wmask_s    = size_mask(size_r) << addr_r[2:0];
  assign wdata_sh_s = wdata_r << {addr_r[2:0], 3'b000};
  assign load_s     = extract_load(mem_rdata, addr_r[2:0], size_r, uns_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; ACCESS always lasts exactly one cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_next_s = misalign_s ? ST_RESP : ST_ACCESS;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS: state_next_s = ST_RESP;
      ST_RESP: begin
        if (resp_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Request capture; fields are frozen once accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r  <= 64'd0;
      wen_r   <= 1'b0;
      size_r  <= 2'd0;
      uns_r   <= 1'b0;
      wdata_r <= 64'd0;
    end else if (accept_s) begin
      addr_r  <= req_addr;
      wen_r   <= req_wen;
      size_r  <= req_size;
      uns_r   <= req_unsigned;
      wdata_r <= req_wdata;
    end
  end

  // Response registers: set on misaligned accept or at the end of ACCESS,
  // held until the consumer takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_r    <= 1'b0;
      resp_rdata_r    <= 64'd0;
      resp_misalign_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && misalign_s) begin
            resp_valid_r    <= 1'b1;
            resp_rdata_r    <= 64'd0;
            resp_misalign_r <= 1'b1;
          end
        end
        ST_ACCESS: begin
          resp_valid_r    <= 1'b1;
          resp_rdata_r    <= wen_r ? 64'd0 : load_s;
          resp_misalign_r <= 1'b0;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
          end
        end
        default: begin
          resp_valid_r    <= 1'b0;
          resp_rdata_r    <= 64'd0;
          resp_misalign_r <= 1'b0;
        end
      endcase
    end
  end

  // Memory port decodes straight from state so an asynchronous reset in
  // ACCESS removes the enable and write strobe immediately.
  always_comb begin
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 64'd0;
    mem_wmask = 8'd0;
    mem_wdata = 64'd0;
    if (state_r == ST_ACCESS) begin
      mem_ce   = 1'b1;
      mem_we   = wen_r;
      mem_addr = {addr_r[63:3], 3'b000};
      if (wen_r) begin
        mem_wmask = wmask_s;
        mem_wdata = wdata_sh_s;
      end else begin
        mem_wmask = 8'd0;
        mem_wdata = 64'd0;
      end
    end else begin
      mem_ce = 1'b0;
    end
  end

  assign req_ready     = (state_r == ST_IDLE);
  assign resp_valid    = resp_valid_r;
  assign resp_rdata    = resp_rdata_r;
  assign resp_misalign = resp_misalign_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl.  Inputs change on the falling
// edge, outputs are sampled on the falling edge; a small monitor counts memory
// enables and writes seen on rising edges.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_misalign;
  logic [63:0] mem_addr;
  logic        mem_ce;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_rdata;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int ce_cnt     = 0;
  int wr_cnt     = 0;

  lsu_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wen      (req_wen),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_misalign(resp_misalign),
    .mem_addr     (mem_addr),
    .mem_ce       (mem_ce),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model bookkeeping: one access per enabled rising edge.
  always @(posedge clk) begin
    if (mem_ce) ce_cnt <= ce_cnt + 1;
    if (mem_ce && mem_we) wr_cnt <= wr_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Runs one complete request with an immediately ready consumer.
  task automatic run_req(input string nm, input logic [63:0] a, input logic w,
                         input logic [1:0] sz, input logic u, input logic [63:0] wd,
                         input logic [63:0] mrd, input logic [7:0] emask,
                         input logic [63:0] ewd, input logic [63:0] erd, input logic emis);
    int ce0;
    @(negedge clk);
    ce0 = ce_cnt;
    check_eq({nm, ".req_ready"}, req_ready, 64'd1);
    req_valid = 1'b1; req_addr = a; req_wen = w; req_size = sz;
    req_unsigned = u; req_wdata = wd; mem_rdata = mrd; resp_ready = 1'b0;
    @(negedge clk);
    // Request fields must be ignored after the accept edge.
    req_valid = 1'b0; req_addr = ~a; req_wen = ~w; req_size = ~sz;
    req_unsigned = ~u; req_wdata = ~wd;
    if (!emis) begin
      check_eq({nm, ".acc_ce"},    mem_ce, 64'd1);
      check_eq({nm, ".acc_we"},    mem_we, {63'd0, w});
      check_eq({nm, ".acc_addr"},  mem_addr, {a[63:3], 3'b000});
      check_eq({nm, ".acc_wmask"}, mem_wmask, emask);
      check_eq({nm, ".acc_wdata"}, mem_wdata, ewd);
      check_eq({nm, ".acc_rvalid"}, resp_valid, 64'd0);
      @(negedge clk);
    end
    check_eq({nm, ".resp_valid"},    resp_valid, 64'd1);
    check_eq({nm, ".resp_misalign"}, resp_misalign, {63'd0, emis});
    check_eq({nm, ".resp_rdata"},    resp_rdata, erd);
    check_eq({nm, ".resp_ce"},       mem_ce, 64'd0);
    check_eq({nm, ".resp_ready_lo"}, req_ready, 64'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_eq({nm, ".done_valid"}, resp_valid, 64'd0);
    check_eq({nm, ".done_ready"}, req_ready, 64'd1);
    check_eq({nm, ".ce_count"}, 64'(ce_cnt - ce0), emis ? 64'd0 : 64'd1);
  endtask

  initial begin
    int w0;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = 64'd0; req_wen = 1'b0;
    req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 64'd0;
    resp_ready = 1'b0; mem_rdata = 64'd0;
    repeat (2) @(negedge clk);
    check_eq("rst.resp_valid", resp_valid, 64'd0);
    check_eq("rst.resp_rdata", resp_rdata, 64'd0);
    check_eq("rst.resp_mis",   resp_misalign, 64'd0);
    check_eq("rst.mem_ce",     mem_ce, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst.req_ready", req_ready, 64'd1);

    //       name    addr          we    sz    u     wdata                rdata                  mask   exp wdata              exp rdata              mis
    run_req("lb",   64'h80000000, 1'b0, 2'd0, 1'b0, 64'd0,               64'h1122334455667788, 8'h00, 64'd0,                 64'hFFFFFFFFFFFFFF88, 1'b0);
    run_req("lbu",  64'h80000000, 1'b0, 2'd0, 1'b1, 64'd0,               64'h1122334455667788, 8'h00, 64'd0,                 64'h0000000000000088, 1'b0);
    run_req("lh",   64'h80000004, 1'b0, 2'd1, 1'b0, 64'd0,               64'h1122334455667788, 8'h00, 64'd0,                 64'h0000000000003344, 1'b0);
    run_req("sw",   64'h80000004, 1'b1, 2'd2, 1'b0, 64'h00000000DEADBEEF, 64'd0,               8'hF0, 64'hDEADBEEF00000000, 64'd0,                 1'b0);
    run_req("lwmis",64'h80000002, 1'b0, 2'd2, 1'b0, 64'd0,               64'h1122334455667788, 8'h00, 64'd0,                 64'd0,                 1'b1);
    run_req("lw",   64'h80000004, 1'b0, 2'd2, 1'b0, 64'd0,               64'h89ABCDEF01234567, 8'h00, 64'd0,                 64'hFFFFFFFF89ABCDEF, 1'b0);
    run_req("lbu7", 64'h80000007, 1'b0, 2'd0, 1'b1, 64'd0,               64'h89ABCDEF01234567, 8'h00, 64'd0,                 64'h0000000000000089, 1'b0);
    run_req("sh6",  64'h80000016, 1'b1, 2'd1, 1'b0, 64'h000000000000BEEF, 64'd0,               8'hC0, 64'hBEEF000000000000, 64'd0,                 1'b0);
    run_req("ld",   64'h80000008, 1'b0, 2'd3, 1'b0, 64'd0,               64'h8877665544332211, 8'h00, 64'd0,                 64'h8877665544332211, 1'b0);
    run_req("sdmis",64'h80000004, 1'b1, 2'd3, 1'b0, 64'h1234,            64'd0,               8'h00, 64'd0,                 64'd0,                 1'b1);

    // Backpressure: response held for three cycles, then a back-to-back request.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 64'h80000000; req_wen = 1'b0; req_size = 2'd1;
    req_unsigned = 1'b0; mem_rdata = 64'h000000000000F00D;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      check_eq("bp.resp_valid", resp_valid, 64'd1);
      check_eq("bp.resp_rdata", resp_rdata, 64'hFFFFFFFFFFFFF00D);
      check_eq("bp.req_ready",  req_ready, 64'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_eq("bp.req_ready_after", req_ready, 64'd1);
    req_valid = 1'b1; req_addr = 64'h80000001; req_wen = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b1; mem_rdata = 64'h000000000000AB00;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("bp.next_ce", mem_ce, 64'd1);
    @(negedge clk);
    check_eq("bp.next_rdata", resp_rdata, 64'h00000000000000AB);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Reset in ACCESS of a double store: strobes drop at once, no write lands.
    w0 = wr_cnt;
    req_valid = 1'b1; req_addr = 64'h80000008; req_wen = 1'b1; req_size = 2'd3;
    req_wdata = 64'hCAFEF00DCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rs.acc_we", mem_we, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rs.ce_drop",    mem_ce, 64'd0);
    check_eq("rs.we_drop",    mem_we, 64'd0);
    check_eq("rs.resp_valid", resp_valid, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rs.req_ready", req_ready, 64'd1);
    check_eq("rs.resp_valid_after", resp_valid, 64'd0);
    check_eq("rs.no_write", 64'(wr_cnt - w0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit controller in the NPC MEM stage, directly upstream of the DPI-backed data memory model. Accepts one load/store request at a time from the pipeline and issues exactly one single-cycle access on the memory port. The access uses an 8-byte-aligned address, a byte write mask, and lane-shifted write data. The block returns a registered, size-extracted, sign/zero-extended load result (or store completion) over a valid/ready response channel.

## Interface
- Parameters: none. Address and data are fixed at 64 bits; memory lanes are 8 bytes.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; 1 only in IDLE.
- req_addr  in  64  byte address.
- req_wen  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  64  store data, right-aligned (LSBs).
- resp_valid  out  1  response held.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  64  extended load data; 0 for stores and faults.
- resp_misalign  out  1  request was misaligned; no memory access was made.
- mem_addr  out  64  req_addr with bits [2:0] cleared.
- mem_ce  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_wdata  out  64  lane-shifted store data.
- mem_wmask  out  8  byte enables.
- mem_rdata  in  64  combinational read data, valid in the same cycle as mem_ce.

## Operation
- FSM states: IDLE, ACCESS, RESP. Encoding is free.
- IDLE
  - req_ready = 1.
  - On req_valid, capture addr/wen/size/unsigned/wdata.
  - If aligned, go to ACCESS.
  - If misaligned, go to RESP with resp_misalign = 1 and resp_rdata = 0.
- Alignment rule: addr[0] must be 0 for half, addr[1:0] = 0 for word, addr[2:0] = 0 for double. Byte is always aligned.
- ACCESS (exactly one cycle)
  - mem_ce = 1, mem_we = captured wen.
  - mem_addr = {addr[63:3], 3'b0}.
  - mem_wmask = ((1 << (1 << size)) - 1) << addr[2:0], truncated to 8 bits.
  - mem_wdata = wdata << (8 * addr[2:0]).
  - Loads: mem_wmask = 0 and mem_wdata = 0.
  - Load result is registered into resp_rdata at end of cycle: sh = mem_rdata >> (8 * addr[2:0]); take the low 8/16/32/64 bits; extend per unsigned.
  - Stores: resp_rdata = 0.
  - Go to RESP.
- RESP
  - resp_valid = 1; resp_rdata and resp_misalign held stable.
  - On resp_ready, go to IDLE.
- Outside ACCESS: mem_ce, mem_we, mem_wmask, mem_wdata, mem_addr are all 0. Memory outputs decode combinationally from state and captured registers.

## Timing
- Reset values: state IDLE; resp_valid 0, resp_rdata 0, resp_misalign 0, mem_* 0. req_ready = 1 immediately after reset deassertion.
- Aligned request accepted at edge k (req_valid & req_ready):
  - ACCESS during cycle k..k+1.
  - resp_valid high from edge k+1 until the edge where resp_ready = 1.
  - Minimum 3 cycles per request.
- Misaligned request accepted at edge k: resp_valid at edge k, i.e. visible in the next cycle. mem_ce is never asserted.
- The response is consumed at edge j (resp_valid & resp_ready). req_ready rises after edge j; a new request cannot be accepted on the same edge.
- resp_ready may be held low indefinitely; all resp_* outputs stay frozen and req_ready stays 0.
- req_* inputs are sampled only at the accept edge; later changes are ignored.
- Reset asserted mid-operation: immediate return to IDLE, mem_ce drops combinationally, pending response discarded. A store in ACCESS at reset assertion must not reach mem_we = 1 after rst_n falls.
- mem_ce is asserted for exactly one cycle per aligned request; there are never two accesses per request.

## Test plan
- Load byte, signed, addr 0x80000000, mem_rdata 0x1122334455667788 -> mem_addr 0x80000000, mem_ce 1 for one cycle, resp_rdata 0xFFFFFFFFFFFFFF88. Same request with unsigned -> 0x0000000000000088.
- Load half, signed, addr 0x80000004, same mem_rdata -> resp_rdata 0x0000000000003344. resp_valid two cycles after the accept edge.
- Store word 0xDEADBEEF at 0x80000004 -> mem_we 1, mem_wmask 0xF0, mem_wdata 0xDEADBEEF00000000, mem_addr 0x80000000, then resp_rdata 0.
- Load word at 0x80000002 -> resp_misalign 1, resp_rdata 0, mem_ce never asserted, resp_valid one cycle after accept.
- Backpressure: hold resp_ready 0 for 3 cycles after resp_valid -> resp_* stable and req_ready 0 throughout. Accept, then the next request is accepted one cycle later.
- Pull rst_n low during ACCESS of a double store at 0x80000008 -> mem_ce/mem_we drop immediately, resp_valid 0, req_ready 1 after release, no write recorded by the memory model.
